// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared definitions for the program counter / instruction fetch stage.
//   ADDR_W_DEF       default program address width
//   DATA_W_DEF       default instruction width
//   STACK_DEPTH_DEF  default return stack depth (power of 2)
//   NOP_INSN         instruction register value after reset
//   state_t          two-state fetch/execute sequencing
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int ADDR_W_DEF      = 11;
    localparam int DATA_W_DEF      = 14;
    localparam int STACK_DEPTH_DEF = 8;

    localparam logic [DATA_W_DEF-1:0] NOP_INSN = 14'h0000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

endpackage

// File: rtl/pc_return_stack.sv
// -----------------------------------------------------------------------------
// pc_return_stack
// Circular hardware return stack. The pointer wraps, so pushing onto a full
// stack overwrites the oldest entry and popping an empty stack returns whatever
// the wrapped pointer selects. Both cases raise a sticky flag cleared by reset.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   push       write push_data at the pointer, then advance the pointer
//   pop        retreat the pointer (pop has priority if both are high)
//   push_data  return address to save
//   top_data   entry just below the pointer (the value a pop returns)
//   ovf        sticky: push made while full
//   unf        sticky: pop made while empty
// -----------------------------------------------------------------------------
module pc_return_stack
    import pc_fetch_pkg::*;
#(
    parameter int DATA_W = ADDR_W_DEF,
    parameter int DEPTH  = STACK_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              unf_q;

    // The count saturates at both ends while the pointer keeps wrapping;
    // that is what gives the overwrite-oldest / read-stale behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (pop) begin
            ptr_q <= ptr_q - PTR_ONE;
            if (cnt_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end else if (push) begin
            ptr_q <= ptr_q + PTR_ONE;
            if (cnt_q == CNT_FULL) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Storage is not reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push && !pop && !rst) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    assign top_data = mem_q[ptr_q - PTR_ONE];
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Non-pipelined program counter and fetch stage in front of the program ROM.
// Each instruction spends one FETCH cycle (latch ROM word, PC+1) followed by
// one or more EXEC cycles, during which the execute core may stall or
// redirect the PC (ret > call > jump > skip).
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   rom_addr_out  ROM address, always equal to the PC
//   rom_data_in   ROM word for rom_addr_out
//   ir_out        instruction register
//   ir_valid      high during EXEC
//   pc_out        current PC
//   stall         hold the current EXEC cycle
//   jump/call/ret/skip  redirect requests, honoured in an unstalled EXEC cycle
//   jump_addr     redirect target for jump and call
//   stk_ovf       sticky return stack overflow
//   stk_unf       sticky return stack underflow
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter int RESET_VECTOR = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [DATA_W-1:0] rom_data_in,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              stall,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic              skip,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              stk_ovf,
    output logic              stk_unf
);

    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_VECTOR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q;

    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_top;

    // Next-state and redirect selection. In FETCH the PC already advances,
    // so during EXEC pc_q is the return address a call must save.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = rom_data_in;
                pc_d    = pc_q + PC_ONE;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    if (ret) begin
                        stk_pop = 1'b1;
                        pc_d    = stk_top;
                    end else if (call) begin
                        stk_push = 1'b1;
                        pc_d     = jump_addr;
                    end else if (jump) begin
                        pc_d = jump_addr;
                    end else if (skip) begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ir_valid is registered from the state being entered so it lines up
    // exactly with the EXEC cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_RESET;
            ir_q       <= DATA_W'(NOP_INSN);
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= (state_d == S_EXEC);
        end
    end

    pc_return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_q),
        .top_data  (stk_top),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

    assign rom_addr_out = pc_q;
    assign pc_out       = pc_q;
    assign ir_out       = ir_q;
    assign ir_valid     = ir_valid_q;

endmodule
